// File: rtl/pacoblaze_pc_sequencer_pkg.sv
// Shared defaults, phase/stack encodings and op-priority decode for the PacoBlaze PC sequencer.
package pacoblaze_pc_sequencer_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 10;
  localparam int unsigned STACK_DEPTH_DEF  = 5;
  localparam int unsigned RESET_VECTOR_DEF = 0;

  typedef enum logic {
    PHASE_FETCH   = 1'b0,
    PHASE_EXECUTE = 1'b1
  } phase_e;

  localparam logic STACK_PUSH = 1'b1;
  localparam logic STACK_POP  = 1'b0;

  typedef enum logic [2:0] {
    OpNone,
    OpCall,
    OpJump,
    OpReturn,
    OpReturni,
    OpInten
  } op_sel_e;

  // Several op_* at once is an illegal decode; resolve it deterministically.
  function automatic op_sel_e op_select(input logic call, input logic jump, input logic ret,
                                        input logic reti, input logic inten);
    if (call)       return OpCall;
    else if (jump)  return OpJump;
    else if (ret)   return OpReturn;
    else if (reti)  return OpReturni;
    else if (inten) return OpInten;
    return OpNone;
  endfunction

endpackage

// File: rtl/pacoblaze_pc_sequencer_if.sv
// Sequencer <-> call/return stack control and data bus.
interface pacoblaze_pc_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  stack_write_enable;
  logic                  stack_update_enable;
  logic                  stack_push_pop;
  logic [ADDR_WIDTH-1:0] stack_data_in;
  logic [ADDR_WIDTH-1:0] stack_data_out;

  modport master (
    output stack_write_enable,
    output stack_update_enable,
    output stack_push_pop,
    output stack_data_in,
    input  stack_data_out
  );

  modport slave (
    input  stack_write_enable,
    input  stack_update_enable,
    input  stack_push_pop,
    input  stack_data_in,
    output stack_data_out
  );
endinterface

// File: rtl/pacoblaze_stack_guard.sv
// Stack occupancy tracker with sticky overflow/underflow flags; saturates at both bounds.
module pacoblaze_stack_guard
  import pacoblaze_pc_sequencer_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  output logic overflow_o,
  output logic underflow_o
);

  localparam logic [STACK_DEPTH:0] Full = {1'b1, {STACK_DEPTH{1'b0}}};
  localparam logic [STACK_DEPTH:0] One  = {{STACK_DEPTH{1'b0}}, 1'b1};

  logic [STACK_DEPTH:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_i) begin
      if (count_q == Full) overflow_d = 1'b1;
      else                 count_d    = count_q + One;
    end else if (pop_i) begin
      if (count_q == '0) underflow_d = 1'b1;
      else               count_d     = count_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/pacoblaze_pc_sequencer.sv
// PacoBlaze program counter, two-phase sequencer and interrupt entry; drives the call/return stack.
// Define PACOBLAZE_STACK_CHECK_EN to add stack occupancy checking and overflow/underflow flags.
module pacoblaze_pc_sequencer
  import pacoblaze_pc_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF),
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR   = '1,
  parameter int unsigned           STACK_DEPTH  = STACK_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_jump_i,
  input  logic                  op_call_i,
  input  logic                  op_return_i,
  input  logic                  op_returni_i,
  input  logic                  returni_ie_i,
  input  logic                  op_inten_i,
  input  logic                  inten_value_i,
  input  logic                  cond_true_i,
  input  logic [ADDR_WIDTH-1:0] target_addr_i,
  input  logic                  interrupt_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  phase_o,
  output logic                  execute_enable_o,
  output logic                  interrupt_ack_o,
  output logic                  ie_o,
`ifdef PACOBLAZE_STACK_CHECK_EN
  output logic                  stack_overflow_o,
  output logic                  stack_underflow_o,
`endif
  pacoblaze_pc_sequencer_if.master stack_if
);

  localparam logic [ADDR_WIDTH-1:0] PcOne = ADDR_WIDTH'(1);

  phase_e                phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ie_q, ie_d;
  logic                  int_pending_q, int_pending_d;
  logic                  push, pop, ack, exec_en;
  op_sel_e               op_sel;

  assign op_sel = op_select(op_call_i, op_jump_i, op_return_i, op_returni_i, op_inten_i);

  always_comb begin
    phase_d       = (phase_q == PHASE_FETCH) ? PHASE_EXECUTE : PHASE_FETCH;
    pc_d          = pc_q;
    ie_d          = ie_q;
    int_pending_d = int_pending_q;
    push          = 1'b0;
    pop           = 1'b0;
    ack           = 1'b0;
    exec_en       = 1'b0;
    if (phase_q == PHASE_FETCH) begin
      int_pending_d = interrupt_i & ie_q;
    end else begin
      int_pending_d = 1'b0;
      if (int_pending_q) begin
        // Preempted instruction is pushed so RETURNI resumes it rather than its successor.
        push = 1'b1;
        pc_d = INT_VECTOR;
        ie_d = 1'b0;
        ack  = 1'b1;
      end else begin
        exec_en = 1'b1;
        pc_d    = pc_q + PcOne;
        case (op_sel)
          OpCall: begin
            if (cond_true_i) begin
              push = 1'b1;
              pc_d = target_addr_i;
            end
          end
          OpJump: begin
            if (cond_true_i) pc_d = target_addr_i;
          end
          OpReturn: begin
            if (cond_true_i) begin
              pop  = 1'b1;
              pc_d = stack_if.stack_data_out + PcOne;
            end
          end
          OpReturni: begin
            pop  = 1'b1;
            pc_d = stack_if.stack_data_out;
            ie_d = returni_ie_i;
          end
          OpInten: ie_d = inten_value_i;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= PHASE_FETCH;
      pc_q          <= RESET_VECTOR;
      ie_q          <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      pc_q          <= pc_d;
      ie_q          <= ie_d;
      int_pending_q <= int_pending_d;
    end
  end

  // Strobes are masked during reset so an abandoned instruction never touches the stack.
  logic push_gated, pop_gated;
  assign push_gated = push & ~reset;
  assign pop_gated  = pop & ~reset;

  assign stack_if.stack_write_enable  = push_gated;
  assign stack_if.stack_update_enable = push_gated | pop_gated;
  assign stack_if.stack_push_pop      = push_gated ? STACK_PUSH : STACK_POP;
  assign stack_if.stack_data_in       = pc_q;

  assign pc_o             = pc_q;
  assign phase_o          = phase_q;
  assign execute_enable_o = exec_en & ~reset;
  assign interrupt_ack_o  = ack & ~reset;
  assign ie_o             = ie_q;

`ifdef PACOBLAZE_STACK_CHECK_EN
  pacoblaze_stack_guard #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack_guard (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_gated),
    .pop_i      (pop_gated),
    .overflow_o (stack_overflow_o),
    .underflow_o(stack_underflow_o)
  );
`endif

endmodule

// File: tb/tb_pacoblaze_pc_sequencer.sv
// Self-checking bench for pacoblaze_pc_sequencer; expected results queued per instruction.
module tb_pacoblaze_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_jump = 0, op_call = 0, op_return = 0, op_returni = 0, returni_ie = 0;
  logic       op_inten = 0, inten_value = 0, cond_true = 0, interrupt = 0;
  logic [9:0] target_addr = '0;
  logic [9:0] pc;
  logic       phase, ee, ack, ie;
`ifdef PACOBLAZE_STACK_CHECK_EN
  logic       ovf, udf;
`endif

  always #5 clk = ~clk;

  pacoblaze_pc_sequencer_if #(.ADDR_WIDTH(10)) sif ();

  pacoblaze_pc_sequencer #(.ADDR_WIDTH(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .op_jump_i       (op_jump),
    .op_call_i       (op_call),
    .op_return_i     (op_return),
    .op_returni_i    (op_returni),
    .returni_ie_i    (returni_ie),
    .op_inten_i      (op_inten),
    .inten_value_i   (inten_value),
    .cond_true_i     (cond_true),
    .target_addr_i   (target_addr),
    .interrupt_i     (interrupt),
    .pc_o            (pc),
    .phase_o         (phase),
    .execute_enable_o(ee),
    .interrupt_ack_o (ack),
    .ie_o            (ie),
`ifdef PACOBLAZE_STACK_CHECK_EN
    .stack_overflow_o (ovf),
    .stack_underflow_o(udf),
`endif
    .stack_if        (sif)
  );

  typedef struct packed {
    logic [9:0] pc_cur;
    logic       ph;
    logic       ee, we, ue, pp;
    logic [9:0] din;
    logic       ack;
    logic [9:0] pc_next;
    logic       ph_after, ack_after, ie_next;
  } obs_t;

  typedef struct {
    logic       call, jump, ret, reti, rie, inten, ival, cond;
    logic [9:0] tgt, sdo;
    logic       irqf, irqe;
    obs_t       exp;
  } instr_t;

  int   n_tests = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  function automatic obs_t ex(input logic [9:0] cur, input logic e, w, u, p, input logic [9:0] d,
                              input logic a, input logic [9:0] nxt, input logic ien);
    return '{pc_cur: cur, ph: 1'b1, ee: e, we: w, ue: u, pp: p, din: (w ? d : 10'h0), ack: a,
             pc_next: nxt, ph_after: 1'b0, ack_after: 1'b0, ie_next: ien};
  endfunction

  // Plain sequential step: no op, no stack, no interrupt.
  function automatic obs_t ex_step(input logic [9:0] cur, input logic [9:0] nxt, input logic ien);
    return ex(cur, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0, nxt, ien);
  endfunction

  function automatic instr_t mk(input logic call, jump, ret, reti, rie, inten, ival, cond,
                                input logic [9:0] tgt, sdo, input logic irqf, irqe, input obs_t e);
    instr_t s;
    s.call = call; s.jump = jump; s.ret = ret; s.reti = reti; s.rie = rie;
    s.inten = inten; s.ival = ival; s.cond = cond; s.tgt = tgt; s.sdo = sdo;
    s.irqf = irqf; s.irqe = irqe; s.exp = e;
    return s;
  endfunction

  // Entered at the falling edge of a FETCH cycle; leaves at the falling edge of the next FETCH.
  task automatic drive_instr(input instr_t s, output obs_t o);
    op_call = s.call; op_jump = s.jump; op_return = s.ret; op_returni = s.reti;
    returni_ie = s.rie; op_inten = s.inten; inten_value = s.ival; cond_true = s.cond;
    target_addr = s.tgt; sif.stack_data_out = s.sdo; interrupt = s.irqf;
    @(posedge clk);
    @(negedge clk);
    interrupt = s.irqe;
    #1;
    o.pc_cur = pc; o.ph = phase; o.ee = ee;
    o.we = sif.stack_write_enable; o.ue = sif.stack_update_enable; o.pp = sif.stack_push_pop;
    o.din = sif.stack_write_enable ? sif.stack_data_in : 10'h0;
    o.ack = ack;
    @(posedge clk);
    #1;
    o.pc_next = pc; o.ph_after = phase; o.ack_after = ack; o.ie_next = ie;
    {op_call, op_jump, op_return, op_returni, op_inten, cond_true, interrupt} = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    op_call = 1'b1; cond_true = 1'b1; op_return = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({pc, phase, ie, ack, sif.stack_write_enable, sif.stack_update_enable,
           sif.stack_push_pop} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: pc=%h phase=%b ie=%b ack=%b we=%b ue=%b pp=%b, required all 0",
                 i, pc, phase, ie, ack, sif.stack_write_enable, sif.stack_update_enable,
                 sif.stack_push_pop);
      end
    end
    {op_call, cond_true, op_return} = '0;
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    instr_t seq[$];
    obs_t   o, e;
    seq.push_back(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 0,0, ex_step(10'h000, 10'h001, 0)));
    seq.push_back(mk(0,0,0,0,0,0,0,1, 10'h0, 10'h0, 0,0, ex_step(10'h001, 10'h002, 0)));
    seq.push_back(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 0,0, ex_step(10'h002, 10'h003, 0)));
    foreach (seq[i]) begin
      exp_q.push_back(seq[i].exp);
      drive_instr(seq[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sequence[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_call_return();
    instr_t seq[$];
    obs_t   o, e;
    seq.push_back(mk(0,1,0,0,0,0,0,1, 10'h010, 10'h0, 0,0, ex_step(10'h003, 10'h010, 0)));
    seq.push_back(mk(1,0,0,0,0,0,0,1, 10'h200, 10'h0, 0,0,
                     ex(10'h010, 1, 1, 1, 1, 10'h010, 0, 10'h200, 0)));
    seq.push_back(mk(0,0,1,0,0,0,0,1, 10'h0, 10'h010, 0,0,
                     ex(10'h200, 1, 0, 1, 0, 10'h0, 0, 10'h011, 0)));
    foreach (seq[i]) begin
      exp_q.push_back(seq[i].exp);
      drive_instr(seq[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL call_return[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_cond_false();
    instr_t seq[$];
    obs_t   o, e;
    seq.push_back(mk(0,1,0,0,0,0,0,1, 10'h020, 10'h0, 0,0, ex_step(10'h011, 10'h020, 0)));
    seq.push_back(mk(1,0,0,0,0,0,0,0, 10'h300, 10'h0, 0,0, ex_step(10'h020, 10'h021, 0)));
    seq.push_back(mk(0,1,0,0,0,0,0,0, 10'h300, 10'h0, 0,0, ex_step(10'h021, 10'h022, 0)));
    seq.push_back(mk(0,0,1,0,0,0,0,0, 10'h0, 10'h100, 0,0, ex_step(10'h022, 10'h023, 0)));
    foreach (seq[i]) begin
      exp_q.push_back(seq[i].exp);
      drive_instr(seq[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cond_false[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_interrupt();
    instr_t seq[$];
    obs_t   o, e;
    // Request while ie=0 is ignored.
    seq.push_back(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 1,1, ex_step(10'h023, 10'h024, 0)));
    seq.push_back(mk(0,0,0,0,0,1,1,1, 10'h0, 10'h0, 0,0, ex_step(10'h024, 10'h025, 1)));
    seq.push_back(mk(0,1,0,0,0,0,0,1, 10'h055, 10'h0, 0,0, ex_step(10'h025, 10'h055, 1)));
    // Sampled in FETCH then dropped: still taken, preempting the CALL.
    seq.push_back(mk(1,0,0,0,0,0,0,1, 10'h123, 10'h0, 1,0,
                     ex(10'h055, 0, 1, 1, 1, 10'h055, 1, 10'h3FF, 0)));
    seq.push_back(mk(0,0,0,1,1,0,0,0, 10'h0, 10'h055, 0,0,
                     ex(10'h3FF, 1, 0, 1, 0, 10'h0, 0, 10'h055, 1)));
    // Raised only during EXECUTE and gone by the next FETCH: never taken.
    seq.push_back(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 0,1, ex_step(10'h055, 10'h056, 1)));
    seq.push_back(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 0,0, ex_step(10'h056, 10'h057, 1)));
    seq.push_back(mk(0,0,1,0,0,0,0,1, 10'h0, 10'h200, 1,1,
                     ex(10'h057, 0, 1, 1, 1, 10'h057, 1, 10'h3FF, 0)));
    seq.push_back(mk(0,0,0,1,0,0,0,1, 10'h0, 10'h057, 0,0,
                     ex(10'h3FF, 1, 0, 1, 0, 10'h0, 0, 10'h057, 0)));
    foreach (seq[i]) begin
      exp_q.push_back(seq[i].exp);
      drive_instr(seq[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL interrupt[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_wrap_priority();
    instr_t seq[$];
    obs_t   o, e;
    seq.push_back(mk(0,1,0,0,0,0,0,1, 10'h3FF, 10'h0, 0,0, ex_step(10'h057, 10'h3FF, 0)));
    seq.push_back(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 0,0, ex_step(10'h3FF, 10'h000, 0)));
    seq.push_back(mk(0,0,1,0,0,0,0,1, 10'h0, 10'h3FF, 0,0,
                     ex(10'h000, 1, 0, 1, 0, 10'h0, 0, 10'h000, 0)));
    seq.push_back(mk(1,1,0,0,0,0,0,1, 10'h0AA, 10'h0, 0,0,
                     ex(10'h000, 1, 1, 1, 1, 10'h000, 0, 10'h0AA, 0)));
    seq.push_back(mk(0,1,1,0,0,0,0,1, 10'h0BB, 10'h100, 0,0, ex_step(10'h0AA, 10'h0BB, 0)));
    seq.push_back(mk(0,0,1,0,0,1,1,1, 10'h0, 10'h0CC, 0,0,
                     ex(10'h0BB, 1, 0, 1, 0, 10'h0, 0, 10'h0CD, 0)));
    seq.push_back(mk(0,0,0,1,1,1,0,1, 10'h0, 10'h0DD, 0,0,
                     ex(10'h0CD, 1, 0, 1, 0, 10'h0, 0, 10'h0DD, 1)));
    foreach (seq[i]) begin
      exp_q.push_back(seq[i].exp);
      drive_instr(seq[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_priority[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    op_call = 1'b1; cond_true = 1'b1; target_addr = 10'h1AB;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({sif.stack_write_enable, sif.stack_update_enable, sif.stack_push_pop, ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_strobe: we=%b ue=%b pp=%b ack=%b, required 0", sif.stack_write_enable,
               sif.stack_update_enable, sif.stack_push_pop, ack);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({pc, phase, ie} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_mid_state: pc=%h phase=%b ie=%b, required 0", pc, phase, ie);
    end
    {op_call, cond_true} = '0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(ex_step(10'h000, 10'h001, 0));
    drive_instr(mk(0,0,0,0,0,0,0,0, 10'h0, 10'h0, 0,0, ex_step(10'h000, 10'h001, 0)), o);
    e = exp_q.pop_front();
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_mid_resume: got %p required %p", o, e);
    end
  endtask

`ifdef PACOBLAZE_STACK_CHECK_EN
  task automatic test_stack_check();
    obs_t o;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      drive_instr(mk(1,0,0,0,0,0,0,1, 10'(i + 16), 10'h0, 0,0, ex_step(10'h0, 10'h0, 0)), o);
      if (i == 31 || i == 32) begin
        n_tests++;
        if ({ovf, udf} !== {(i == 32), 1'b0}) begin
          n_fail++;
          $display("FAIL overflow_after_%0d_calls: ovf=%b udf=%b, required ovf=%b udf=0", i + 1,
                   ovf, udf, (i == 32));
        end
      end
    end
    do_reset();
    n_tests++;
    if ({ovf, udf} !== 2'b00) begin
      n_fail++;
      $display("FAIL flags_cleared: ovf=%b udf=%b, required 0 0", ovf, udf);
    end
    drive_instr(mk(0,0,1,0,0,0,0,1, 10'h0, 10'h0, 0,0, ex_step(10'h0, 10'h0, 0)), o);
    n_tests++;
    if ({ovf, udf} !== 2'b01) begin
      n_fail++;
      $display("FAIL underflow: ovf=%b udf=%b, required 0 1", ovf, udf);
    end
    do_reset();
    n_tests++;
    if ({ovf, udf} !== 2'b00) begin
      n_fail++;
      $display("FAIL underflow_cleared: ovf=%b udf=%b, required 0 0", ovf, udf);
    end
  endtask
`endif

  initial begin
    sif.stack_data_out = '0;
    test_reset();
    test_sequence();
    test_call_return();
    test_cond_false();
    test_interrupt();
    test_wrap_priority();
    test_reset_mid();
`ifdef PACOBLAZE_STACK_CHECK_EN
    test_stack_check();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pacoblaze_pc_sequencer.md
Name: pacoblaze_pc_sequencer

Overview:
Program-counter and control-flow sequencer for the PacoBlaze core. It sits directly upstream of the call/return stack.
- Computes the next instruction address each instruction.
- Drives the stack's write/update/push-pop controls and data input.
- Consumes the stack's combinational data output on RETURN/RETURNI.
- Owns the interrupt-enable flag and the interrupt entry sequence.

Parameters:
ADDR_WIDTH, 10, program address width; equals stack entry width.
RESET_VECTOR, 0, PC value after reset.
INT_VECTOR, 2**ADDR_WIDTH-1, PC loaded on interrupt entry.
STACK_DEPTH, 5, log2 of stack entry count (32 entries).

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
op_jump  in  1  decoded JUMP; valid in EXECUTE phase
op_call  in  1  decoded CALL
op_return  in  1  decoded RETURN
op_returni  in  1  decoded RETURNI
returni_ie  in  1  IE value to restore on RETURNI
op_inten  in  1  decoded ENABLE/DISABLE INTERRUPT
inten_value  in  1  IE value written by op_inten
cond_true  in  1  branch condition result; 1 for unconditional forms
target_addr  in  ADDR_WIDTH  JUMP/CALL destination
interrupt  in  1  level interrupt request
stack_data_out  in  ADDR_WIDTH  stack output, combinational top-of-stack for the selected direction
pc  out  ADDR_WIDTH  current instruction address
phase  out  1  0=FETCH, 1=EXECUTE
execute_enable  out  1  high in EXECUTE unless the instruction is preempted by an interrupt
interrupt_ack  out  1  one-cycle pulse on interrupt entry
ie  out  1  interrupt-enable flag
stack_write_enable  out  1  write stack_data_in at the stack pointer
stack_update_enable  out  1  move the stack pointer
stack_push_pop  out  1  1=push, 0=pop
stack_data_in  out  ADDR_WIDTH  address to push

Behaviour:
- Reset values: pc=RESET_VECTOR, phase=0, ie=0, interrupt_ack=0, all stack controls 0.
  - Reset mid-instruction abandons it; no stack strobe is issued in the reset cycle.
- Phase toggles every clock, so each instruction takes 2 cycles. pc changes only on the EXECUTE→FETCH edge.
- Interrupt sampling: at the FETCH cycle, if interrupt && ie, set internal int_pending.
- EXECUTE with int_pending (the interrupt takes priority over every op, including CALL and RETURN):
  - execute_enable=0.
  - stack_write_enable=1, stack_update_enable=1, stack_push_pop=1, stack_data_in=pc (the unexecuted instruction is pushed).
  - Next pc=INT_VECTOR; ie<=0; interrupt_ack=1 for this cycle only; int_pending clears.
- EXECUTE without an interrupt (execute_enable=1):
  - op_call && cond_true: push pc (write+update, push_pop=1, data_in=pc); next pc=target_addr.
  - op_jump && cond_true: next pc=target_addr; no stack activity.
  - op_return && cond_true: pop (update=1, write=0, push_pop=0); next pc=stack_data_out+1.
  - op_returni: pop; next pc=stack_data_out (no +1); ie<=returni_ie.
  - op_inten: ie<=inten_value.
  - All other cases, including condition false: next pc=pc+1.
- Arithmetic is modulo 2**ADDR_WIDTH: pc+1 from all-ones wraps to 0, and stack_data_out+1 wraps identically.
- push_pop is driven to 0 whenever no push occurs, so stack_data_out presents the pop candidate in the same cycle.
- More than one op_* asserted at once is illegal decode. The required priority is call > jump > return > returni > inten.
- Interrupt raised in EXECUTE is not seen until the next FETCH. An interrupt dropped after FETCH sampling is still taken.
- Stack pointer wrap is owned by the stack. The sequencer does not block overflowing pushes or underflowing pops.

Optional Feature:
PACOBLAZE_STACK_CHECK_EN:
- Defined: adds a STACK_DEPTH+1-bit occupancy counter, incremented on push and decremented on pop, reset to 0.
- Adds outputs stack_overflow and stack_underflow, both sticky until reset.
  - stack_overflow sets on a push at occupancy 2**STACK_DEPTH.
  - stack_underflow sets on a pop at occupancy 0.
  - The counter saturates at both bounds.
- Undefined: no counter and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package/include: ADDR_WIDTH, STACK_DEPTH, RESET_VECTOR, INT_VECTOR defaults, phase encoding constants (PHASE_FETCH=0, PHASE_EXECUTE=1), and push/pop encoding (1/0).
- One natural sub-module: pacoblaze_stack_guard, containing the occupancy counter and sticky flags; instantiated only under PACOBLAZE_STACK_CHECK_EN.
- Next-PC mux stays inline.

Test Plan:
- Reset release, no ops: pc steps 0,1,2 every 2 cycles; phase alternates; no stack strobes.
- At pc=0x010, CALL 0x200 true: push data_in=0x010, next pc=0x200. Then RETURN with stack_data_out=0x010: pop strobe, next pc=0x011.
- CALL with cond_true=0 at pc=0x020: no stack strobes, next pc=0x021.
- ie=1, interrupt raised in FETCH at pc=0x055 (op_call=1): execute_enable=0, push 0x055, pc=0x3FF, ack for exactly 1 cycle, ie=0. Then RETURNI returni_ie=1, stack_data_out=0x055: pc=0x055, ie=1.
- pc=0x3FF with no op: next pc=0x000. RETURN with stack_data_out=0x3FF: next pc=0x000.
- PACOBLAZE_STACK_CHECK_EN: 33 consecutive CALLs set stack_overflow on the 33rd. After reset, one RETURN sets stack_underflow. Reset clears both flags.
